alu_exec: RTL

Execute stage of the RISC CPU datapath that consumes the conditioned B operand from the B-operand option mux, together with the A operand and an opcode. It computes a WIDTH-bit result and condition flags. Logic and add ops complete in one cycle; shifts and multiply are iterative. Input and output sides use valid/ready handshakes so the pipeline controller can stall on multi-cycle ops.

---
 rtl/alu_exec.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ADD/logic ops, iterative shifts and optional MUL,
// valid/ready on both sides. Define ALU_MUL_EN to build the shift-and-add multiplier.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_AND = 4'd1;
  localparam logic [3:0] OP_OR  = 4'd2;
  localparam logic [3:0] OP_XOR = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_SRA = 4'd6;
  localparam logic [3:0] OP_MUL = 4'd7;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; out_valid and the result payload hold until that transfer.

  logic [1:0]       state;
  logic [WIDTH-1:0] a_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] prod_next;
`endif

  logic [WIDTH:0]   sum;
  logic [SW-1:0]    shamt;
  logic             is_shift;
  logic             is_mul;
  logic             is_legal;
  logic [WIDTH-1:0] imm_res;
  logic             imm_c;
  logic             imm_v;
  logic [WIDTH-1:0] sh_next;
  logic [WIDTH-1:0] done_val;

  assign in_ready  = (state == IDLE);
  assign dbg_state = state;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, b};
    shamt    = b[SW-1:0];
    is_shift = (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
`ifdef ALU_MUL_EN
    is_mul   = (op == OP_MUL);
`else
    is_mul   = 1'b0;
`endif
    is_legal = (op <= OP_SRA) || is_mul;
    imm_res  = '0;
    imm_c    = 1'b0;
    imm_v    = 1'b0;
    case (op)
      OP_ADD: begin
        imm_res = sum[WIDTH-1:0];
        imm_c   = sum[WIDTH];
        imm_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND: imm_res = a & b;
      OP_OR:  imm_res = a | b;
      OP_XOR: imm_res = a ^ b;
      OP_SLL, OP_SRL, OP_SRA: imm_res = a;
      default: imm_res = '0;
    endcase
  end

  // One-bit step of the iterative shifter; SRA keeps the sign bit.
  always_comb begin
    case (op_q)
      OP_SLL:  sh_next = {a_q[WIDTH-2:0], 1'b0};
      OP_SRL:  sh_next = {1'b0, a_q[WIDTH-1:1]};
      OP_SRA:  sh_next = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
      default: sh_next = a_q;
    endcase
  end

`ifdef ALU_MUL_EN
  assign prod_next = acc_q + (b_q[0] ? a_q : '0);
  assign done_val  = (op_q == OP_MUL) ? prod_next : sh_next;
`else
  assign done_val  = sh_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      op_q      <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      err       <= 1'b0;
`ifdef ALU_MUL_EN
      b_q       <= '0;
      acc_q     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q  <= a;
            op_q <= op;
            err  <= 1'b0;
`ifdef ALU_MUL_EN
            b_q   <= b;
            acc_q <= '0;
`endif
            if (is_shift && (shamt != '0)) begin
              state <= BUSY;
              cnt   <= {1'b0, shamt};
            end else if (is_mul) begin
              state <= BUSY;
              cnt   <= CW'(WIDTH);
            end else begin
              // Illegal ops land here with imm_res=0, giving flags {1,0,0,0}.
              state     <= DONE;
              out_valid <= 1'b1;
              result    <= imm_res;
              flags     <= {(imm_res == '0), imm_res[WIDTH-1], imm_c, imm_v};
              err       <= !is_legal;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - CW'(1);
`ifdef ALU_MUL_EN
          if (op_q == OP_MUL) begin
            acc_q <= prod_next;
            a_q   <= {a_q[WIDTH-2:0], 1'b0};
            b_q   <= {1'b0, b_q[WIDTH-1:1]};
          end else begin
            a_q <= sh_next;
          end
`else
          a_q <= sh_next;
`endif
          if (cnt == CW'(1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= done_val;
            flags     <= {(done_val == '0), done_val[WIDTH-1], 2'b00};
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
